// File: rtl/xadc_aux_sampler.sv
// xadc_aux_sampler: reads up to 16 XADC aux channels over DRP on each EOC, optionally averages, publishes per slot.
// Optional per-slot min/max tracking is compiled in when the macro AUX_MINMAX_EN is defined.
module xadc_aux_sampler #(
  parameter int          NUM_CH      = 2,
  parameter logic [63:0] AUX_LIST    = 64'h0000_0000_0000_0020,
  parameter int          AVG_LOG2    = 0,
  parameter int          DRP_TIMEOUT = 64
) (
  input  logic                   DCLK,
  input  logic                   RESET,
  input  logic                   EOC,
  input  logic [4:0]             CHANNEL,
  output logic [6:0]             DADDR,
  output logic                   DEN,
  output logic                   DWE,
  output logic [15:0]            DI,
  input  logic [15:0]            DO,
  input  logic                   DRDY,
  output logic [16*NUM_CH-1:0]   MEASURED_AUX,
  output logic [NUM_CH-1:0]      SAMPLE_VALID,
  output logic                   BUSY,
  output logic                   OVERRUN,
  output logic                   DRP_ERR
`ifdef AUX_MINMAX_EN
  ,
  input  logic                   CLEAR_MINMAX,
  output logic [16*NUM_CH-1:0]   MIN_AUX,
  output logic [16*NUM_CH-1:0]   MAX_AUX
`endif
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = 16 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TW = $clog2(DRP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DRP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  function automatic logic [3:0] aux_of(input logic [SW-1:0] slot);
    aux_of = AUX_LIST[4*slot +: 4];
  endfunction

  // Descending scan so the lowest-numbered slot listing the channel wins.
  function automatic logic [SW:0] lookup(input logic [4:0] ch);
    logic [SW:0] res;
    res = {(SW+1){1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch[4] && (AUX_LIST[4*k +: 4] == ch[3:0])) begin
        res = {1'b1, SW'(k)};
      end
    end
    return res;
  endfunction

  state_t              state_r, next_s;
  logic                hit_s, match_s;
  logic [SW-1:0]       hit_slot_s;
  logic                start_s, take_pend_s, timeout_s;
  logic [SW-1:0]       start_slot_s;
  logic [SW-1:0]       slot_r;
  logic                pend_valid_r;
  logic [SW-1:0]       pend_slot_r;
  logic [6:0]          daddr_r;
  logic                den_r;
  logic [TW-1:0]       tmo_r;
  logic [AW-1:0]       acc_r [NUM_CH];
  logic [CW-1:0]       cnt_r [NUM_CH];
  logic                capture_s, last_s;
  logic [AW-1:0]       sum_s;
  logic [15:0]         pub_s;
  logic [16*NUM_CH-1:0] meas_r;
  logic [NUM_CH-1:0]   valid_r;
  logic                busy_r, overrun_r, drp_err_r;

  assign {hit_s, hit_slot_s} = lookup(CHANNEL);
  assign match_s = EOC & hit_s;

  // State register.
  always_ff @(posedge DCLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode; a live EOC outranks the pending entry, which then stays queued.
  always_comb begin
    next_s       = state_r;
    start_s      = 1'b0;
    start_slot_s = hit_slot_s;
    take_pend_s  = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (match_s) begin
          next_s  = ST_ISSUE;
          start_s = 1'b1;
        end else if (pend_valid_r) begin
          next_s       = ST_ISSUE;
          start_s      = 1'b1;
          start_slot_s = pend_slot_r;
          take_pend_s  = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_ISSUE: next_s = ST_WAIT;
      ST_WAIT: begin
        if (DRDY) begin
          next_s = ST_UPDATE;
        end else if (tmo_r == TMO_LAST) begin
          next_s    = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          next_s = ST_WAIT;
        end
      end
      ST_UPDATE: next_s = ST_IDLE;
      default:   next_s = ST_IDLE;
    endcase
  end

  // Accumulation is folded into the DRDY edge so results appear the cycle after DRDY.
  always_comb begin
    capture_s = (state_r == ST_WAIT) && DRDY;
    sum_s     = acc_r[slot_r] + AW'(DO);
    last_s    = (cnt_r[slot_r] == CNT_LAST);
    pub_s     = 16'(sum_s >> AVG_LOG2);
  end

  // DRP handshake, pending queue, timeout counter and sticky flags.
  always_ff @(posedge DCLK) begin
    if (RESET) begin
      den_r        <= 1'b0;
      daddr_r      <= 7'h00;
      slot_r       <= {SW{1'b0}};
      tmo_r        <= {TW{1'b0}};
      pend_valid_r <= 1'b0;
      pend_slot_r  <= {SW{1'b0}};
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      drp_err_r    <= 1'b0;
    end else begin
      den_r  <= start_s;
      busy_r <= (next_s != ST_IDLE);
      if (start_s) begin
        slot_r  <= start_slot_s;
        daddr_r <= 7'h10 + {3'b000, aux_of(start_slot_s)};
      end
      if (state_r == ST_WAIT) begin
        tmo_r <= tmo_r + TW'(1);
      end else begin
        tmo_r <= {TW{1'b0}};
      end
      if (timeout_s) begin
        drp_err_r <= 1'b1;
      end
      if (state_r != ST_IDLE) begin
        if (match_s) begin
          pend_valid_r <= 1'b1;
          pend_slot_r  <= hit_slot_s;
          if (pend_valid_r) begin
            overrun_r <= 1'b1;
          end
        end
      end else if (take_pend_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  // Per-slot accumulators, sample counters and published results.
  always_ff @(posedge DCLK) begin
    if (RESET) begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc_r[k] <= {AW{1'b0}};
        cnt_r[k] <= {CW{1'b0}};
      end
      meas_r  <= {(16*NUM_CH){1'b0}};
      valid_r <= {NUM_CH{1'b0}};
    end else begin
      valid_r <= {NUM_CH{1'b0}};
      if (capture_s) begin
        if (last_s) begin
          acc_r[slot_r]            <= {AW{1'b0}};
          cnt_r[slot_r]            <= {CW{1'b0}};
          meas_r[16*slot_r +: 16]  <= pub_s;
          valid_r[slot_r]          <= 1'b1;
        end else begin
          acc_r[slot_r] <= sum_s;
          cnt_r[slot_r] <= cnt_r[slot_r] + CW'(1);
        end
      end
    end
  end

`ifdef AUX_MINMAX_EN
  logic [16*NUM_CH-1:0] min_r, max_r;

  // Running extremes; a publish in the clear cycle seeds both with the new value.
  always_ff @(posedge DCLK) begin
    if (RESET) begin
      min_r <= {NUM_CH{16'hFFFF}};
      max_r <= {NUM_CH{16'h0000}};
    end else begin
      if (CLEAR_MINMAX) begin
        min_r <= {NUM_CH{16'hFFFF}};
        max_r <= {NUM_CH{16'h0000}};
      end
      if (capture_s && last_s) begin
        if (CLEAR_MINMAX || (pub_s < min_r[16*slot_r +: 16])) begin
          min_r[16*slot_r +: 16] <= pub_s;
        end
        if (CLEAR_MINMAX || (pub_s > max_r[16*slot_r +: 16])) begin
          max_r[16*slot_r +: 16] <= pub_s;
        end
      end
    end
  end

  assign MIN_AUX = min_r;
  assign MAX_AUX = max_r;
`endif

  assign DADDR        = daddr_r;
  assign DEN          = den_r;
  assign DWE          = 1'b0;
  assign DI           = 16'h0000;
  assign MEASURED_AUX = meas_r;
  assign SAMPLE_VALID = valid_r;
  assign BUSY         = busy_r;
  assign OVERRUN      = overrun_r;
  assign DRP_ERR      = drp_err_r;

endmodule
